// File: rtl/e203_exu_brslv_q_pkg.sv
// Shared definitions for the E203 branch resolve unit: default widths, flush-type
// one-hot encoding, instruction-length increments and FSM states.
package e203_exu_brslv_q_pkg;

  localparam int PC_SIZE_DEF = 32;
  localparam int XLEN_DEF    = 32;

  // One-hot flush type; bit positions double as indices into type vectors
  localparam int FT_MRET_BIT   = 0;
  localparam int FT_DRET_BIT   = 1;
  localparam int FT_FENCEI_BIT = 2;
  localparam int FT_BJP_BIT    = 3;

  localparam logic [3:0] FT_MRET   = 4'b0001;
  localparam logic [3:0] FT_DRET   = 4'b0010;
  localparam logic [3:0] FT_FENCEI = 4'b0100;
  localparam logic [3:0] FT_BJP    = 4'b1000;

  localparam logic [2:0] ILEN_INCR_32 = 3'd4;
  localparam logic [2:0] ILEN_INCR_16 = 3'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } brslv_state_e;

  function automatic logic [2:0] f_ilen_incr(input logic rv32);
    return rv32 ? ILEN_INCR_32 : ILEN_INCR_16;
  endfunction

endpackage

// File: rtl/e203_exu_brslv_tgt.sv
// Combinational redirect-target computation shared by the registered and
// combinational flush modes. All arithmetic wraps modulo 2^PC_SIZE.
module e203_exu_brslv_tgt
  import e203_exu_brslv_q_pkg::*;
#(
  parameter int PC_SIZE = PC_SIZE_DEF,
  parameter int XLEN    = XLEN_DEF
) (
  input  logic               i_rv32,
  input  logic               i_bjp,
  input  logic               i_bjp_prdt,
  input  logic               i_fencei,
  input  logic               i_dret,
  input  logic [PC_SIZE-1:0] i_pc,
  input  logic [XLEN-1:0]    i_imm,
  input  logic [PC_SIZE-1:0] i_epc,
  input  logic [PC_SIZE-1:0] i_dpc,
  output logic [PC_SIZE-1:0] o_tgt_pc
);

  logic [PC_SIZE-1:0] w_seq_pc;
  logic [PC_SIZE-1:0] w_jmp_pc;

  assign w_seq_pc = i_pc + PC_SIZE'(f_ilen_incr(i_rv32));
  assign w_jmp_pc = i_pc + i_imm[PC_SIZE-1:0];

  // Immediate bits above the PC width cannot affect a wrapped target
  if (XLEN > PC_SIZE) begin : g_imm_hi
    logic w_unused_imm_hi;
    assign w_unused_imm_hi = ^i_imm[XLEN-1:PC_SIZE];
  end

  // Predicted-taken branches that resolve otherwise fall through to the sequential PC
  always_comb begin
    o_tgt_pc = i_epc;
    if (i_fencei | (i_bjp & i_bjp_prdt)) begin
      o_tgt_pc = w_seq_pc;
    end else if (i_bjp) begin
      o_tgt_pc = w_jmp_pc;
    end else if (i_dret) begin
      o_tgt_pc = i_dpc;
    end
  end

endmodule

// File: rtl/e203_exu_brslv_q.sv
// E203 EXU branch resolve unit: REG_FLUSH=1 registers the flush in a one-entry
// pending FSM, REG_FLUSH=0 is combinational. Counters need E203_BRSLV_PERF_CNT_EN.
module e203_exu_brslv_q
  import e203_exu_brslv_q_pkg::*;
#(
  parameter int PC_SIZE   = PC_SIZE_DEF,
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_FLUSH = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmt_i_valid,
  output logic               cmt_i_ready,
  input  logic               cmt_i_rv32,
  input  logic               cmt_i_bjp,
  input  logic               cmt_i_bjp_prdt,
  input  logic               cmt_i_bjp_rslv,
  input  logic               cmt_i_fencei,
  input  logic               cmt_i_mret,
  input  logic               cmt_i_dret,
  input  logic [PC_SIZE-1:0] cmt_i_pc,
  input  logic [XLEN-1:0]    cmt_i_imm,
  input  logic [PC_SIZE-1:0] csr_epc_r,
  input  logic [PC_SIZE-1:0] csr_dpc_r,
  input  logic               nonalu_excpirq_flush_req_raw,
  output logic               brchmis_flush_req,
  input  logic               brchmis_flush_ack,
  output logic [PC_SIZE-1:0] brchmis_flush_pc,
  output logic               cmt_mret_ena,
  output logic               cmt_dret_ena,
  output logic               cmt_fencei_ena,
  input  logic               perf_clr,
  output logic [CNT_W-1:0]   perf_bjp_cnt,
  output logic [CNT_W-1:0]   perf_mis_cnt
);

  logic [3:0]         w_type;
  logic               w_brch_class;
  logic               w_need_flush;
  logic [PC_SIZE-1:0] w_tgt_pc;
  logic               w_ready;
  logic               w_req;
  logic [PC_SIZE-1:0] w_flush_pc;
  logic [2:0]         w_ena;

  assign w_type = ({4{cmt_i_mret}}   & FT_MRET)
                | ({4{cmt_i_dret}}   & FT_DRET)
                | ({4{cmt_i_fencei}} & FT_FENCEI)
                | ({4{cmt_i_bjp}}    & FT_BJP);

  assign w_brch_class = |w_type;
  assign w_need_flush = (w_type[FT_BJP_BIT] & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv))
                      | w_type[FT_FENCEI_BIT] | w_type[FT_MRET_BIT] | w_type[FT_DRET_BIT];

  e203_exu_brslv_tgt #(
    .PC_SIZE (PC_SIZE),
    .XLEN    (XLEN)
  ) u_tgt (
    .i_rv32     (cmt_i_rv32),
    .i_bjp      (cmt_i_bjp),
    .i_bjp_prdt (cmt_i_bjp_prdt),
    .i_fencei   (cmt_i_fencei),
    .i_dret     (cmt_i_dret),
    .i_pc       (cmt_i_pc),
    .i_imm      (cmt_i_imm),
    .i_epc      (csr_epc_r),
    .i_dpc      (csr_dpc_r),
    .o_tgt_pc   (w_tgt_pc)
  );

  if (REG_FLUSH != 0) begin : g_reg_flush
    brslv_state_e       r_state;
    brslv_state_e       w_state_next;
    logic [PC_SIZE-1:0] r_pc;
    logic [2:0]         r_type;
    logic               w_capture;
    logic               w_hsk;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_IDLE;
        r_pc    <= '0;
        r_type  <= '0;
      end else begin
        r_state <= w_state_next;
        if (w_capture) begin
          r_pc   <= w_tgt_pc;
          r_type <= w_type[2:0];
        end
      end
    end

    // The pending entry survives non-ALU flushes; they only mask the request
    always_comb begin
      w_state_next = r_state;
      w_ready      = 1'b0;
      w_req        = 1'b0;
      w_capture    = 1'b0;
      w_hsk        = 1'b0;
      case (r_state)
        ST_IDLE: begin
          w_ready = ~(w_brch_class & nonalu_excpirq_flush_req_raw);
          if (cmt_i_valid & w_ready & w_need_flush) begin
            w_capture    = 1'b1;
            w_state_next = ST_PEND;
          end
        end
        ST_PEND: begin
          w_req = ~nonalu_excpirq_flush_req_raw;
          w_hsk = w_req & brchmis_flush_ack;
          if (w_hsk) begin
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end

    assign w_flush_pc = r_pc;
    assign w_ena      = r_type & {3{w_hsk}};
  end else begin : g_comb_flush
    logic w_unused_comb;

    assign w_unused_comb = clk ^ rst_n;
    assign w_req         = cmt_i_valid & w_need_flush & ~nonalu_excpirq_flush_req_raw;
    assign w_ready       = ~w_brch_class
                         | ((w_need_flush ? brchmis_flush_ack : 1'b1) & ~nonalu_excpirq_flush_req_raw);
    assign w_flush_pc    = w_tgt_pc;
    assign w_ena         = w_type[2:0] & {3{w_req & brchmis_flush_ack}};
  end

  assign cmt_i_ready       = w_ready;
  assign brchmis_flush_req = w_req;
  assign brchmis_flush_pc  = w_flush_pc;
  assign cmt_mret_ena      = w_ena[FT_MRET_BIT];
  assign cmt_dret_ena      = w_ena[FT_DRET_BIT];
  assign cmt_fencei_ena    = w_ena[FT_FENCEI_BIT];

`ifdef E203_BRSLV_PERF_CNT_EN
  logic [CNT_W-1:0] r_bjp_cnt;
  logic [CNT_W-1:0] r_mis_cnt;
  logic             w_bjp_acc;
  logic             w_mis_acc;

  assign w_bjp_acc = cmt_i_valid & w_ready & cmt_i_bjp;
  assign w_mis_acc = w_bjp_acc & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv);

  // Saturating counters; clear wins over a coincident increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bjp_cnt <= '0;
      r_mis_cnt <= '0;
    end else if (perf_clr) begin
      r_bjp_cnt <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_bjp_acc && (r_bjp_cnt != '1)) begin
        r_bjp_cnt <= r_bjp_cnt + CNT_W'(1);
      end
      if (w_mis_acc && (r_mis_cnt != '1)) begin
        r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end
    end
  end

  assign perf_bjp_cnt = r_bjp_cnt;
  assign perf_mis_cnt = r_mis_cnt;
`else
  logic w_unused_perf;

  assign w_unused_perf = perf_clr;
  assign perf_bjp_cnt  = '0;
  assign perf_mis_cnt  = '0;
`endif

endmodule

// File: doc/e203_exu_brslv_q.md
Name: e203_exu_brslv_q

Overview:
Next-generation branch resolve unit for the E203 EXU commit stage.
- Resolves committed branch-class instructions (BJP, FENCE.I, MRET, DRET).
- Computes the redirect target PC internally with its own adders.
- REG_FLUSH=1 (default) captures the flush request into a one-entry pending register, cutting the commit-to-IFU timing path.
- REG_FLUSH=0 gives the legacy combinational behaviour.
- Sits between ALU commit and the IFU flush interface; the non-ALU exception/IRQ flush has priority over it.

Parameters:
PC_SIZE, 32, PC and target width
XLEN, 32, immediate width (XLEN >= PC_SIZE)
REG_FLUSH, 1, 1 = registered flush with pending state; 0 = combinational flush
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmt_i_valid  in  1  commit instruction valid
cmt_i_ready  out  1  commit instruction accepted
cmt_i_rv32  in  1  1 = 32-bit instruction, 0 = 16-bit instruction
cmt_i_bjp  in  1  branch or jump
cmt_i_bjp_prdt  in  1  predicted taken
cmt_i_bjp_rslv  in  1  resolved taken
cmt_i_fencei  in  1  FENCE.I
cmt_i_mret  in  1  MRET
cmt_i_dret  in  1  DRET
cmt_i_pc  in  PC_SIZE  instruction PC
cmt_i_imm  in  XLEN  branch offset
csr_epc_r  in  PC_SIZE  MEPC
csr_dpc_r  in  PC_SIZE  DPC
nonalu_excpirq_flush_req_raw  in  1  higher-priority flush request
brchmis_flush_req  out  1  flush request to IFU
brchmis_flush_ack  in  1  flush acknowledge from IFU
brchmis_flush_pc  out  PC_SIZE  redirect target
cmt_mret_ena  out  1  MRET side-effect pulse
cmt_dret_ena  out  1  DRET side-effect pulse
cmt_fencei_ena  out  1  FENCE.I side-effect pulse
perf_clr  in  1  synchronous clear of performance counters
perf_bjp_cnt  out  CNT_W  committed BJP count
perf_mis_cnt  out  CNT_W  mispredicted BJP count

Behaviour:
Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.

need_flush = (bjp & (prdt ^ rslv)) | fencei | mret | dret.

Target PC, computed modulo 2^PC_SIZE, first match wins:
- fencei | (bjp & prdt): pc + (rv32 ? 4 : 2)
- bjp & ~prdt: pc + imm[PC_SIZE-1:0]
- dret: dpc
- otherwise (mret): epc

REG_FLUSH=1, two-state FSM IDLE/PEND:
- Reset state: IDLE. All outputs 0; pending pc/type registers 0.
- IDLE, cmt_i_ready: 1 unless (branch-class & nonalu_excpirq_flush_req_raw).
- IDLE, entering PEND: on accepted valid & need_flush, capture target PC and type (mret/dret/fencei) and move to PEND. Non-flushing instructions pass through with no state change.
- PEND, cmt_i_ready: 0 for all instructions (wrong-path block).
- PEND, brchmis_flush_req: 1 & ~nonalu_excpirq_flush_req_raw. brchmis_flush_pc shows the registered target.
- PEND, non-ALU priority: nonalu_excpirq_flush_req_raw only masks the request; the entry is retained, never dropped.
- PEND, handshake (req & ack): return to IDLE next cycle and pulse the matching cmt_*_ena for one cycle, combinationally with the handshake. The next commit is accepted no earlier than the cycle after the handshake (1-cycle bubble).
- Latency: commit to flush_req is 1 cycle.

REG_FLUSH=0, fully combinational:
- brchmis_flush_req = valid & need_flush & ~nonalu.
- flush_pc is the live target.
- cmt_i_ready = ~branch_class | ((need_flush ? ack : 1) & ~nonalu).
- ena outputs = type & req & ack.
- No state.

Reset mid-operation: a PEND entry is discarded and no ena pulse is produced.

Optional Feature:
E203_BRSLV_PERF_CNT_EN
- Defined:
  - perf_bjp_cnt increments on every accepted bjp commit.
  - perf_mis_cnt increments on every accepted bjp commit with prdt ^ rslv.
  - Both counters saturate at all-ones.
  - perf_clr has priority over increment; the counters read 0 on the cycle after perf_clr.
  - Both counters reset to 0.
- Undefined: counter outputs are tied to 0, no flops are instantiated, and perf_clr is ignored.

Decomposition:
- Shared defines package: PC_SIZE/XLEN defaults, the flush-type encoding (MRET, DRET, FENCEI, BJP as a one-hot 4-bit value), and ILEN increments 4/2.
- Sub-module e203_exu_brslv_tgt: combinational target-PC computation, reused by both modes.
- Counters stay inline.

Test Plan:
- Mispredict: REG_FLUSH=1; bjp prdt=0 rslv=1, pc=0x8000_0100, imm=0x40, rv32=1, ack held 0 for 3 cycles then 1 -> flush_req rises cycle+1, flush_pc=0x8000_0140, cmt_i_ready=0 throughout PEND, return to IDLE the cycle after ack.
- Predicted-taken, not taken: bjp prdt=1 rslv=0, pc=0x200, rv32=0 -> flush_pc=0x202; correctly predicted bjp -> no flush, ready=1, perf_bjp_cnt+1, perf_mis_cnt unchanged.
- MRET: MRET with epc=0x1234 while nonalu raw=1 for 2 cycles during PEND -> req masked for those 2 cycles, entry kept, then req=1, flush_pc=0x1234, cmt_mret_ena single pulse on the handshake.
- Wrap-around: pc=0xFFFF_FFFE, fencei, rv32=1 -> flush_pc=0x0000_0002, cmt_fencei_ena pulse; repeat with REG_FLUSH=0 -> same target, req in the same cycle, ready=ack.
- Counters: preload counters near all-ones, issue 3 mispredicts -> both saturate at all-ones; perf_clr with a coincident bjp -> counters 0 next cycle.
- Reset in PEND: assert rst_n=0 while PEND with req=1 -> req=0 immediately (asynchronous), no ena pulse, IDLE after release.
